// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    TRAP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, holds each fetched word
// for decode, and squashes in-flight fetches made stale by a redirect.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misaligned
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic         squash;

  // Request is masked during reset so memory never sees a fetch while we clear.
  assign imem_req  = (state == FETCH) && !reset;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      squash      <= 1'b0;
      misaligned  <= 1'b0;
    end else if (redirect && (state != TRAP)) begin
      instr_valid <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state      <= TRAP;
        misaligned <= 1'b1;
      end else begin
        fetch_pc <= redirect_pc;
        case (state)
          FETCH: begin
            // An accepted old-address request still owes us a response to discard.
            if (imem_ready) begin
              state  <= WAIT;
              squash <= 1'b1;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              state  <= FETCH;
              squash <= 1'b0;
            end else begin
              squash <= 1'b1;
            end
          end
          HOLD:    state <= FETCH;
          default: state <= state;
        endcase
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= FETCH;
            end else begin
              instruction <= imem_rdata;
              pc          <= fetch_pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            fetch_pc    <= fetch_pc + PC_STEP;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        TRAP: state <= TRAP;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// checked against a transaction-level program-order model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        misaligned;

  int vectors = 0;
  int miscompares = 0;

  int unsigned mem_ready_pct = 100;
  int unsigned mem_lat = 0;
  bit          mem_lat_rand = 1'b0;

  instr_fetch dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instruction(instruction),
    .pc(pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of address; address 0 holds 0x00500093.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  // Instruction memory: accepts on req&ready at an edge, answers after mem_lat more cycles.
  initial begin : memory_model
    bit          pend = 1'b0;
    bit          acc_last = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    logic [31:0] pend_addr = 32'h0;
    int unsigned pend_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend        = 1'b0;
        acc_last    = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (acc_last) begin
          pend      = 1'b1;
          pend_addr = acc_addr;
          pend_cnt  = mem_lat_rand ? $urandom_range(0, 3) : mem_lat;
        end
        if (pend) begin
          if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        imem_ready = ($urandom_range(0, 99) < mem_ready_pct);
        acc_last   = imem_req && imem_ready;
        acc_addr   = imem_addr;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset       = 1'b1;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit ok;
    mem_ready_pct = 100; mem_lat = 0; mem_lat_rand = 1'b0;
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({imem_req, instr_valid, misaligned, pc, instruction} !== {3'b000, 32'h0, 32'h13}) begin
      miscompares++;
      $display("[TB] FAIL reset_values: req/vld/mis=%b%b%b pc=%h instr=%h want 000 0 00000013",
               imem_req, instr_valid, misaligned, pc, instruction);
    end
    reset = 1'b0;
    @(negedge clk);
    wait_valid(20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL reset_pre_valid: instr_valid=%b want 1 within budget", instr_valid);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({imem_req, instr_valid, pc, instruction} !== {2'b00, 32'h0, 32'h13}) begin
      miscompares++;
      $display("[TB] FAIL reset_async_clear: req/vld=%b%b pc=%h instr=%h want 00 0 00000013",
               imem_req, instr_valid, pc, instruction);
    end
  endtask

  task automatic test_first_fetch();
    mem_ready_pct = 100; mem_lat = 0; mem_lat_rand = 1'b0;
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL first_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    vectors++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL first_wait: req=%b vld=%b want 0 0", imem_req, instr_valid);
    end
    @(negedge clk);
    vectors++;
    if ({instr_valid, pc, instruction} !== {1'b1, 32'h0, 32'h0050_0093}) begin
      miscompares++;
      $display("[TB] FAIL first_deliver: vld=%b pc=%h instr=%h want 1 00000000 00500093",
               instr_valid, pc, instruction);
    end
    @(negedge clk);
    vectors++;
    if ({instr_valid, imem_req, imem_addr} !== {2'b01, 32'h4}) begin
      miscompares++;
      $display("[TB] FAIL first_next_req: vld=%b req=%b addr=%h want 0 1 00000004",
               instr_valid, imem_req, imem_addr);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    bit ok;
    bit bad;
    logic [31:0] hp;
    logic [31:0] hi;
    mem_ready_pct = 100; mem_lat = 0; mem_lat_rand = 1'b0;
    do_reset();
    @(negedge clk);
    wait_valid(20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL hold_reach: instr_valid=%b want 1 within budget", instr_valid);
    end
    hp = pc;
    hi = instruction;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({instr_valid, imem_req, pc, instruction} !== {2'b10, hp, hi}) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad || hi !== mem_word(hp)) begin
      miscompares++;
      $display("[TB] FAIL hold_stable: pc=%h instr=%h vld=%b req=%b want stable pc=%h instr=%h",
               pc, instruction, instr_valid, imem_req, hp, mem_word(hp));
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    vectors++;
    if ({instr_valid, imem_req, imem_addr} !== {2'b01, hp + 32'd4}) begin
      miscompares++;
      $display("[TB] FAIL hold_release: vld=%b req=%b addr=%h want 0 1 %h",
               instr_valid, imem_req, imem_addr, hp + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit bad;
    mem_ready_pct = 100; mem_lat = 2; mem_lat_rand = 1'b0;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    bad = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) bad = 1'b1;
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (bad || !ok || imem_addr !== 32'h100) begin
      miscompares++;
      $display("[TB] FAIL redirect_wait_squash: stale_valid=%b req_seen=%b addr=%h want 0 1 00000100",
               bad, ok, imem_addr);
    end
    wait_valid(20, ok);
    vectors++;
    if (!ok || pc !== 32'h100 || instruction !== mem_word(32'h100)) begin
      miscompares++;
      $display("[TB] FAIL redirect_wait_deliver: vld=%b pc=%h instr=%h want 1 00000100 %h",
               instr_valid, pc, instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    mem_ready_pct = 100; mem_lat = 0; mem_lat_rand = 1'b0;
    do_reset();
    @(negedge clk);
    wait_valid(20, ok);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect    = 1'b0;
    instr_ready = 1'b0;
    vectors++;
    if (!ok || {instr_valid, imem_req, imem_addr} !== {2'b01, 32'h40}) begin
      miscompares++;
      $display("[TB] FAIL redirect_hold_addr: vld=%b req=%b addr=%h want 0 1 00000040",
               instr_valid, imem_req, imem_addr);
    end
    wait_valid(20, ok);
    vectors++;
    if (!ok || pc !== 32'h40 || instruction !== mem_word(32'h40)) begin
      miscompares++;
      $display("[TB] FAIL redirect_hold_deliver: pc=%h instr=%h want 00000040 %h",
               pc, instruction, mem_word(32'h40));
    end
  endtask

  task automatic test_misaligned();
    bit bad;
    mem_ready_pct = 100; mem_lat = 0; mem_lat_rand = 1'b0;
    do_reset();
    instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ({misaligned, imem_req, instr_valid} !== 3'b100) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL misaligned_trap: mis=%b req=%b vld=%b want 1 0 0 for 8 cycles",
               misaligned, imem_req, instr_valid);
    end
    instr_ready = 1'b0;
    do_reset();
    @(negedge clk);
    vectors++;
    if ({misaligned, imem_req, imem_addr} !== {2'b01, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL misaligned_reset: mis=%b req=%b addr=%h want 0 1 00000000",
               misaligned, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem_ready_pct = 100; mem_lat = 0; mem_lat_rand = 1'b0;
    do_reset();
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    wait_req(20, ok);
    vectors++;
    if (!ok || imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("[TB] FAIL wrap_req: req=%b addr=%h want 1 fffffffc", imem_req, imem_addr);
    end
    wait_valid(20, ok);
    vectors++;
    if (!ok || pc !== 32'hFFFF_FFFC || instruction !== mem_word(32'hFFFF_FFFC)) begin
      miscompares++;
      $display("[TB] FAIL wrap_deliver: pc=%h instr=%h want fffffffc %h",
               pc, instruction, mem_word(32'hFFFF_FFFC));
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_next: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  // Program-order model: the next word decode sees is the redirect target, else the
  // previous accepted pc + 4; valid must drop right after any accept or redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    bit          drop;
    int          delivered;
    mem_ready_pct = 60; mem_lat = 0; mem_lat_rand = 1'b1;
    do_reset();
    exp_pc    = 32'h0;
    drop      = 1'b0;
    delivered = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (drop) begin
        vectors++;
        if (instr_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rand_valid_drop: cycle %0d vld=%b want 0", cyc, instr_valid);
        end
      end
      if (instr_valid) begin
        vectors++;
        if (pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
          miscompares++;
          $display("[TB] FAIL rand_deliver: cycle %0d pc=%h instr=%h want %h %h",
                   cyc, pc, instruction, exp_pc, mem_word(exp_pc));
        end
      end
      if (imem_req) begin
        vectors++;
        if (imem_addr !== exp_pc) begin
          miscompares++;
          $display("[TB] FAIL rand_req_addr: cycle %0d addr=%h want %h", cyc, imem_addr, exp_pc);
        end
      end
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      if (redirect) begin
        exp_pc = redirect_pc;
        drop   = 1'b1;
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        drop   = 1'b1;
        delivered++;
      end else begin
        drop = 1'b0;
      end
      @(negedge clk);
    end
    redirect    = 1'b0;
    instr_ready = 1'b0;
    vectors++;
    if (delivered < 50) begin
      miscompares++;
      $display("[TB] FAIL rand_progress: delivered=%0d want >= 50", delivered);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misaligned();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
